// File: rtl/mem_port_arbiter_if.sv
// Bundle of writer, reader and memory-side signals for the two-port memory arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface mem_port_arbiter_if;
    logic        wr_req;
    logic        wr_valid;
    logic [23:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        wr_gnt;

    logic        rd_req;
    logic        rd_urgent;
    logic        rd_valid;
    logic [23:0] rd_addr;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        rd_data_valid;
    logic        rd_gnt;

    logic        mem_valid;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        mem_rdata_valid;

    // Handshake: a transfer happens on a rising clk_120 edge where valid and ready
    // are both 1; valid never waits on ready, ready may depend on valid.
    modport slave (
        input  wr_req, wr_valid, wr_addr, wr_data,
        output wr_ready, wr_gnt,
        input  rd_req, rd_urgent, rd_valid, rd_addr,
        output rd_ready, rd_data, rd_data_valid, rd_gnt,
        output mem_valid, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata, mem_rdata_valid
    );

    modport master (
        output wr_req, wr_valid, wr_addr, wr_data,
        input  wr_ready, wr_gnt,
        output rd_req, rd_urgent, rd_valid, rd_addr,
        input  rd_ready, rd_data, rd_data_valid, rd_gnt,
        input  mem_valid, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata, mem_rdata_valid
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory command port between a frame-copy writer and a display reader,
// with urgent-read preemption, a MAX_BURST fairness limit and an idle cycle between owners.
module mem_port_arbiter #(
    parameter int MAX_BURST = 800
) (
    input  logic                clk_120,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus,
    output logic [1:0]          o_dbg_state,
    output logic [10:0]         o_dbg_beat_cnt
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_WR      = 2'd1;
    localparam logic [1:0]  S_RD      = 2'd2;
    localparam logic [10:0] LP_MAX    = 11'(MAX_BURST);
    localparam logic [10:0] LP_MAX_M1 = 11'(MAX_BURST - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_last_rd;
    logic [10:0] r_beat_cnt;
    logic        r_wr_gnt;
    logic        r_rd_gnt;
    logic        w_beat;
    logic        w_at_limit;
    logic        w_rd_urgent;
    logic        w_enter;

    always_comb begin
        bus.mem_valid = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.wr_ready  = 1'b0;
        bus.rd_ready  = 1'b0;
        case (r_state)
            S_WR: begin
                bus.mem_valid = bus.wr_valid;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = bus.wr_addr;
                bus.mem_wdata = bus.wr_data;
                bus.wr_ready  = bus.mem_ready;
            end
            S_RD: begin
                bus.mem_valid = bus.rd_valid;
                bus.mem_addr  = bus.rd_addr;
                bus.rd_ready  = bus.mem_ready;
            end
            default: ;
        endcase
    end

    assign w_beat      = bus.mem_valid & bus.mem_ready;
    assign w_rd_urgent = bus.rd_req & bus.rd_urgent;
    // Limit counts the beat completing this cycle, so a contested burst stops at exactly MAX_BURST beats.
    assign w_at_limit  = (r_beat_cnt == LP_MAX) | ((r_beat_cnt == LP_MAX_M1) & w_beat);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_rd_urgent)                    w_state_nxt = S_RD;
                else if (bus.wr_req && bus.rd_req)  w_state_nxt = r_last_rd ? S_WR : S_RD;
                else if (bus.wr_req)                w_state_nxt = S_WR;
                else if (bus.rd_req)                w_state_nxt = S_RD;
            end
            S_WR: begin
                if (!bus.wr_req || (w_at_limit && bus.rd_req) || w_rd_urgent)
                    w_state_nxt = S_IDLE;
            end
            S_RD: begin
                if (!bus.rd_req || (w_at_limit && bus.wr_req))
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_enter = (r_state == S_IDLE) && (w_state_nxt != S_IDLE);

    always_ff @(posedge clk_120 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_last_rd  <= 1'b1;
            r_beat_cnt <= '0;
            r_wr_gnt   <= 1'b0;
            r_rd_gnt   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_gnt <= (w_state_nxt == S_WR);
            r_rd_gnt <= (w_state_nxt == S_RD);
            if (w_enter) begin
                r_beat_cnt <= '0;
                r_last_rd  <= (w_state_nxt == S_RD);
            end else if (w_beat && (r_beat_cnt != LP_MAX)) begin
                r_beat_cnt <= r_beat_cnt + 11'd1;
            end
        end
    end

    assign bus.wr_gnt        = r_wr_gnt;
    assign bus.rd_gnt        = r_rd_gnt;
    assign bus.rd_data       = bus.mem_rdata;
    assign bus.rd_data_valid = bus.mem_rdata_valid;
    assign o_dbg_state       = r_state;
    assign o_dbg_beat_cnt    = r_beat_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration and datapath tables, then
// burst, fairness, preemption, backpressure and reset sequences.
module tb_mem_port_arbiter;

    logic        clk_120 = 1'b0;
    logic        rst_n   = 1'b0;
    logic [1:0]  dbg_state;
    logic [10:0] dbg_cnt;
    int          n_chk = 0;
    int          n_err = 0;
    logic [23:0] exp_q[$];

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MAX_BURST(800)) dut (
        .clk_120        (clk_120),
        .rst_n          (rst_n),
        .bus            (bus),
        .o_dbg_state    (dbg_state),
        .o_dbg_beat_cnt (dbg_cnt)
    );

    always #5 clk_120 = ~clk_120;

    typedef struct packed {
        logic wr_req;
        logic rd_req;
        logic rd_urgent;
        logic exp_wr_gnt;
        logic exp_rd_gnt;
    } arb_vec_t;

    typedef struct packed {
        logic        rd_side;
        logic        valid;
        logic [23:0] addr;
        logic [15:0] data;
        logic        mem_ready;
        logic        exp_mem_valid;
        logic        exp_mem_we;
        logic [23:0] exp_addr;
        logic [15:0] exp_wdata;
        logic        exp_wr_ready;
        logic        exp_rd_ready;
    } dp_vec_t;

    arb_vec_t arb_tbl[7];
    dp_vec_t  dp_tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_120);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        bus.wr_req = 0; bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_req = 0; bus.rd_urgent = 0; bus.rd_valid = 0; bus.rd_addr = '0;
        bus.mem_ready = 0; bus.mem_rdata = '0; bus.mem_rdata_valid = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        cyc();
        cyc();
        rst_n = 1;
    endtask

    initial begin
        int beats;
        int errs;
        int rdy_cnt;
        int addr_next;

        arb_tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        arb_tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        arb_tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        arb_tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        arb_tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        arb_tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        arb_tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        dp_tbl[0] = '{1'b0, 1'b1, 24'h123456, 16'habcd, 1'b1, 1'b1, 1'b1, 24'h123456, 16'habcd, 1'b1, 1'b0};
        dp_tbl[1] = '{1'b0, 1'b0, 24'h000010, 16'h1111, 1'b1, 1'b0, 1'b1, 24'h000010, 16'h1111, 1'b1, 1'b0};
        dp_tbl[2] = '{1'b0, 1'b1, 24'hffffff, 16'hffff, 1'b0, 1'b1, 1'b1, 24'hffffff, 16'hffff, 1'b0, 1'b0};
        dp_tbl[3] = '{1'b1, 1'b1, 24'h00abcd, 16'h7777, 1'b1, 1'b1, 1'b0, 24'h00abcd, 16'h0000, 1'b0, 1'b1};
        dp_tbl[4] = '{1'b1, 1'b1, 24'h3fffff, 16'h1234, 1'b0, 1'b1, 1'b0, 24'h3fffff, 16'h0000, 1'b0, 1'b0};
        dp_tbl[5] = '{1'b1, 1'b0, 24'h000001, 16'h0001, 1'b1, 1'b0, 1'b0, 24'h000001, 16'h0000, 1'b0, 1'b1};

        // Reset state, with requests already asserted
        clear_inputs();
        bus.wr_req = 1; bus.rd_req = 1; bus.wr_valid = 1; bus.mem_ready = 1;
        rst_n = 0;
        cyc(); cyc(); settle();
        chk("rst_wr_gnt", bus.wr_gnt, 0);
        chk("rst_rd_gnt", bus.rd_gnt, 0);
        chk("rst_mem_valid", bus.mem_valid, 0);
        chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_rd_ready", bus.rd_ready, 0);
        chk("rst_state", dbg_state, 0);
        chk("rst_beat_cnt", dbg_cnt, 0);

        // Arbitration from IDLE straight after reset
        for (int i = 0; i < 7; i++) begin
            do_reset();
            bus.wr_req = arb_tbl[i].wr_req;
            bus.rd_req = arb_tbl[i].rd_req;
            bus.rd_urgent = arb_tbl[i].rd_urgent;
            settle();
            chk("arb_pre_gnt", {bus.wr_gnt, bus.rd_gnt}, 0);
            cyc(); settle();
            chk("arb_wr_gnt", bus.wr_gnt, arb_tbl[i].exp_wr_gnt);
            chk("arb_rd_gnt", bus.rd_gnt, arb_tbl[i].exp_rd_gnt);
            clear_inputs();
            cyc(); cyc();
        end

        // Datapath muxing under each owner
        for (int i = 0; i < 6; i++) begin
            do_reset();
            if (dp_tbl[i].rd_side) bus.rd_req = 1; else bus.wr_req = 1;
            cyc();
            bus.mem_ready = dp_tbl[i].mem_ready;
            bus.wr_data = dp_tbl[i].data;
            if (dp_tbl[i].rd_side) begin
                bus.rd_valid = dp_tbl[i].valid; bus.rd_addr = dp_tbl[i].addr;
                bus.wr_valid = 1; bus.wr_addr = 24'h555555;
            end else begin
                bus.wr_valid = dp_tbl[i].valid; bus.wr_addr = dp_tbl[i].addr;
                bus.rd_valid = 1; bus.rd_addr = 24'h555555;
            end
            settle();
            chk("dp_mem_valid", bus.mem_valid, dp_tbl[i].exp_mem_valid);
            chk("dp_mem_we", bus.mem_we, dp_tbl[i].exp_mem_we);
            chk("dp_mem_addr", bus.mem_addr, dp_tbl[i].exp_addr);
            chk("dp_mem_wdata", bus.mem_wdata, dp_tbl[i].exp_wdata);
            chk("dp_wr_ready", bus.wr_ready, dp_tbl[i].exp_wr_ready);
            chk("dp_rd_ready", bus.rd_ready, dp_tbl[i].exp_rd_ready);
            clear_inputs();
            cyc(); cyc();
        end

        // Single writer: 640 beats at addresses 0..639
        do_reset();
        bus.wr_req = 1; bus.wr_valid = 1; bus.mem_ready = 1;
        settle();
        chk("s1_idle_no_beat", bus.mem_valid | bus.wr_ready, 0);
        cyc(); settle();
        chk("s1_wr_gnt_cycle2", bus.wr_gnt, 1);
        beats = 0; errs = 0;
        for (int i = 0; i < 640; i++) begin
            bus.wr_addr = 24'(i);
            bus.wr_data = 16'(i);
            settle();
            if (bus.mem_valid && bus.wr_ready) begin
                beats++;
                if (bus.mem_addr !== 24'(i) || bus.mem_we !== 1'b1 || bus.mem_wdata !== 16'(i)) errs++;
            end
            cyc();
        end
        chk("s1_beats", beats, 640);
        chk("s1_beat_errs", errs, 0);
        bus.wr_req = 0; bus.wr_valid = 0;
        settle();
        chk("s1_beat_cnt", dbg_cnt, 640);
        chk("s1_gnt_in_release", bus.wr_gnt, 1);
        cyc(); settle();
        chk("s1_idle_after", dbg_state, 0);
        chk("s1_gnt_dropped", bus.wr_gnt, 0);

        // Simultaneous requests: writer first, gap, then reader; then back to writer
        do_reset();
        bus.wr_req = 1; bus.rd_req = 1;
        cyc(); settle();
        chk("s2_wr_first", {bus.wr_gnt, bus.rd_gnt}, 2'b10);
        cyc();
        bus.wr_req = 0;
        cyc(); settle();
        chk("s2_gap", {bus.wr_gnt, bus.rd_gnt}, 2'b00);
        cyc(); settle();
        chk("s2_rd_next", {bus.wr_gnt, bus.rd_gnt}, 2'b01);
        bus.rd_valid = 1;
        settle();
        chk("s2_rd_we", bus.mem_we, 0);
        bus.wr_req = 1; bus.rd_req = 0;
        cyc(); settle();
        chk("s2_gap2", {bus.wr_gnt, bus.rd_gnt}, 2'b00);
        cyc(); settle();
        chk("s2_wr_again", {bus.wr_gnt, bus.rd_gnt}, 2'b10);

        // Fairness limit: writer wants 2000 beats while reader waits
        do_reset();
        bus.wr_req = 1; bus.rd_req = 1; bus.wr_valid = 1; bus.mem_ready = 1;
        cyc();
        beats = 0;
        for (int c = 0; c < 1000; c++) begin
            settle();
            if (!bus.wr_gnt) break;
            if (bus.mem_valid && bus.wr_ready) beats++;
            cyc();
        end
        chk("s3_released", bus.wr_gnt, 0);
        chk("s3_beats", beats, 800);
        chk("s3_gap", bus.rd_gnt, 0);
        cyc(); settle();
        chk("s3_rd_gnt", bus.rd_gnt, 1);

        // Urgent read preempts the writer at beat 100
        do_reset();
        bus.wr_req = 1; bus.wr_valid = 1; bus.mem_ready = 1;
        cyc();
        for (int i = 0; i < 100; i++) cyc();
        bus.rd_req = 1; bus.rd_urgent = 1;
        settle();
        chk("s4_beat100_done", bus.mem_valid & bus.wr_ready, 1);
        cyc(); settle();
        chk("s4_cnt", dbg_cnt, 101);
        chk("s4_idle", {bus.wr_gnt, bus.rd_gnt}, 2'b00);
        cyc(); settle();
        chk("s4_rd_gnt", bus.rd_gnt, 1);
        chk("s4_mem_we", bus.mem_we, 0);

        // Backpressure: mem_ready alternates during a write burst
        do_reset();
        bus.wr_req = 1; bus.wr_valid = 1;
        for (int i = 0; i < 20; i++) exp_q.push_back(24'(i));
        cyc();
        errs = 0; rdy_cnt = 0; addr_next = 0;
        for (int c = 0; c < 40; c++) begin
            bus.mem_ready = (c % 2 == 0);
            bus.wr_addr = 24'(addr_next);
            settle();
            if (bus.wr_ready) rdy_cnt++;
            if (bus.mem_valid && bus.mem_ready) begin
                if (exp_q.size() == 0) errs++;
                else if (bus.mem_addr !== exp_q.pop_front()) errs++;
                addr_next++;
            end
            cyc();
        end
        chk("s5_ready_cnt", rdy_cnt, 20);
        chk("s5_beat_cnt", dbg_cnt, 20);
        chk("s5_sb_errs", errs, 0);
        chk("s5_sb_left", exp_q.size(), 0);

        // Reset mid-read-burst, then read-return pass-through
        do_reset();
        bus.rd_req = 1; bus.rd_valid = 1; bus.mem_ready = 1; bus.rd_addr = 24'h00007b;
        cyc(); settle();
        chk("s6_rd_gnt", bus.rd_gnt, 1);
        chk("s6_rd_ready", bus.rd_ready, 1);
        bus.mem_rdata = 16'h1357; bus.mem_rdata_valid = 0;
        cyc(); settle();
        chk("s6_rdata_pass", bus.rd_data, 16'h1357);
        chk("s6_rdv_low", bus.rd_data_valid, 0);
        rst_n = 0;
        settle();
        chk("s6_async_gnt", bus.rd_gnt, 0);
        chk("s6_async_valid", bus.mem_valid, 0);
        chk("s6_async_ready", bus.rd_ready, 0);
        chk("s6_async_cnt", dbg_cnt, 0);
        cyc();
        rst_n = 1;
        bus.rd_req = 0;
        bus.mem_rdata = 16'hbeef; bus.mem_rdata_valid = 1;
        settle();
        chk("s6_rdata_after", bus.rd_data, 16'hbeef);
        chk("s6_rdv_after", bus.rd_data_valid, 1);
        chk("s6_no_gnt", bus.rd_gnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
